// File: rtl/ctr_pkg.sv
// ctr_pkg: shared definitions for the programmable up/down counter.
//   mode_e          - end-of-range behaviour encodings
//   DEF_WIDTH       - default count width
//   DEF_PRESCALE_W  - default prescaler width
package ctr_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11  // behaves as wrap
  } mode_e;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 16;

endpackage

// File: rtl/ctr_prescaler.sv
// ctr_prescaler: enable-gated divider producing a tick every prescale+1 enabled cycles.
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count enable; 0 freezes the divider
//   clear     - synchronous clear of the divider (wins over counting)
//   prescale  - terminal divider value
//   tick      - combinational, high when en=1 and divider == prescale
module ctr_prescaler
  import ctr_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_q, div_d;

  assign tick = en && (div_q == prescale);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else if (en) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/prog_updown_counter.sv
// prog_updown_counter: bounded up/down counter with wrap, saturate and bounce end modes.
//   clk, rst          - clock, asynchronous active-high reset
//   en                - run enable (0 = pause)
//   dir               - requested direction (1 = up)
//   mode              - 00 wrap, 01 saturate, 10 bounce, 11 wrap
//   min_val, max_val  - inclusive bounds
//   step              - increment per tick (0 acts as 1)
//   prescale          - tick every prescale+1 enabled cycles
//   load, load_val    - synchronous load, value clamped to the bounds
//   count             - registered count
//   cur_dir           - registered effective direction
//   tc                - registered terminal-count pulse
//   at_min, at_max    - combinational bound flags
//   cfg_err           - combinational, min_val > max_val
module prog_updown_counter
  import ctr_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      min_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [WIDTH-1:0]      step,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic                  cur_dir,
  output logic                  tc,
  output logic                  at_min,
  output logic                  at_max,
  output logic                  cfg_err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             cur_dir_q, cur_dir_d;
  logic             tc_q, tc_d;

  logic             tick;
  logic             load_ok;
  logic             bounce;
  logic             eff_dir;
  logic             outside;
  logic             at_term;
  mode_e            mode_dec;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] term_val;

  // One extra bit so overshoot and borrow are visible before clamping.
  logic [WIDTH:0]   cnt_x, min_x, max_x, step_x;
  logic [WIDTH:0]   sum_up, sum_dn, next_up, next_dn, next_mv;

  assign mode_dec = mode_e'(mode);
  assign bounce   = (mode_dec == MODE_BOUNCE);
  assign cfg_err  = (min_val > max_val);
  assign load_ok  = load && !cfg_err;

  // Bounce keeps its own direction; other modes follow dir directly.
  assign eff_dir  = bounce ? cur_dir_q : dir;

  assign at_min   = (count_q == min_val);
  assign at_max   = (count_q == max_val);
  assign outside  = (count_q < min_val) || (count_q > max_val);
  assign at_term  = eff_dir ? at_max : at_min;
  assign term_val = eff_dir ? max_val : min_val;

  assign cnt_x    = {1'b0, count_q};
  assign min_x    = {1'b0, min_val};
  assign max_x    = {1'b0, max_val};
  assign step_x   = (step == '0) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, step};
  assign sum_up   = cnt_x + step_x;
  assign sum_dn   = cnt_x - step_x;
  assign next_up  = (sum_up > max_x) ? max_x : sum_up;
  // MSB of sum_dn is the borrow: step was larger than count.
  assign next_dn  = (sum_dn[WIDTH] || (sum_dn < min_x)) ? min_x : sum_dn;
  assign next_mv  = eff_dir ? next_up : next_dn;

  assign load_clamped = (load_val < min_val) ? min_val :
                        (load_val > max_val) ? max_val : load_val;

  ctr_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (load_ok),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    count_d   = count_q;
    cur_dir_d = cur_dir_q;
    tc_d      = 1'b0;

    if (load_ok) begin
      count_d   = load_clamped;
      cur_dir_d = dir;
    end else begin
      if (en && !bounce) begin
        cur_dir_d = dir;
      end
      if (tick && !cfg_err) begin
        if (outside) begin
          // Re-enter the range at the starting bound for this direction.
          count_d = eff_dir ? min_val : max_val;
        end else if (at_term) begin
          unique case (mode_dec)
            MODE_SAT: begin
              count_d = count_q;
            end
            MODE_BOUNCE: begin
              cur_dir_d = ~cur_dir_q;
              count_d   = cur_dir_q ? next_dn[WIDTH-1:0] : next_up[WIDTH-1:0];
              tc_d      = 1'b1;
            end
            MODE_WRAP, MODE_RSVD: begin
              count_d = eff_dir ? min_val : max_val;
              tc_d    = 1'b1;
            end
            default: begin
              count_d = count_q;
            end
          endcase
        end else begin
          count_d = next_mv[WIDTH-1:0];
          tc_d    = (next_mv[WIDTH-1:0] == term_val);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      cur_dir_q <= 1'b1;
      tc_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      cur_dir_q <= cur_dir_d;
      tc_q      <= tc_d;
    end
  end

  assign count   = count_q;
  assign cur_dir = cur_dir_q;
  assign tc      = tc_q;

endmodule

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter: table-driven directed bench for prog_updown_counter.
module tb_prog_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  min_val = 8'd0;
  logic [7:0]  max_val = 8'd255;
  logic [7:0]  step = 8'd1;
  logic [15:0] prescale = 16'd0;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'd0;
  logic [7:0]  count;
  logic        cur_dir;
  logic        tc;
  logic        at_min;
  logic        at_max;
  logic        cfg_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        en;
    logic        dir;
    logic [1:0]  mode;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  st;
    logic [15:0] pre;
    logic        ld;
    logic [7:0]  lv;
    logic [7:0]  e_cnt;
    logic        e_dir;
    logic        e_tc;
  } vec_t;

  vec_t vecs[$];

  prog_updown_counter #(
    .WIDTH      (8),
    .PRESCALE_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .min_val  (min_val),
    .max_val  (max_val),
    .step     (step),
    .prescale (prescale),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .cur_dir  (cur_dir),
    .tc       (tc),
    .at_min   (at_min),
    .at_max   (at_max),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input int md, input int dr, input int mn, input int mx, input int st,
                     input int pre, input int e, input int ld, input int lv,
                     input int e_cnt, input int e_dir, input int e_tc);
    vec_t v;
    v.mode  = 2'(md);
    v.dir   = 1'(dr);
    v.mn    = 8'(mn);
    v.mx    = 8'(mx);
    v.st    = 8'(st);
    v.pre   = 16'(pre);
    v.en    = 1'(e);
    v.ld    = 1'(ld);
    v.lv    = 8'(lv);
    v.e_cnt = 8'(e_cnt);
    v.e_dir = 1'(e_dir);
    v.e_tc  = 1'(e_tc);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    en       = v.en;
    dir      = v.dir;
    mode     = v.mode;
    min_val  = v.mn;
    max_val  = v.mx;
    step     = v.st;
    prescale = v.pre;
    load     = v.ld;
    load_val = v.lv;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " count"}, int'(count), int'(v.e_cnt));
    check({tag, " cur_dir"}, int'(cur_dir), int'(v.e_dir));
    check({tag, " tc"}, int'(tc), int'(v.e_tc));
    check({tag, " at_min"}, int'(at_min), int'(v.e_cnt == v.mn));
    check({tag, " at_max"}, int'(at_max), int'(v.e_cnt == v.mx));
    check({tag, " cfg_err"}, int'(cfg_err), int'(v.mn > v.mx));
  endtask

  initial begin
    vec_t h;

    // Wrap up 3..6
    add(0, 1, 3, 6, 1, 0, 0, 1, 3, 3, 1, 0);
    add(0, 1, 3, 6, 1, 0, 1, 0, 0, 4, 1, 0);
    add(0, 1, 3, 6, 1, 0, 1, 0, 0, 5, 1, 0);
    add(0, 1, 3, 6, 1, 0, 1, 0, 0, 6, 1, 1);
    add(0, 1, 3, 6, 1, 0, 1, 0, 0, 3, 1, 1);
    // Saturate down, step 4 from 10
    add(1, 0, 0, 20, 4, 0, 0, 1, 10, 10, 0, 0);
    add(1, 0, 0, 20, 4, 0, 1, 0, 0, 6, 0, 0);
    add(1, 0, 0, 20, 4, 0, 1, 0, 0, 2, 0, 0);
    add(1, 0, 0, 20, 4, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 20, 4, 0, 1, 0, 0, 0, 0, 0);
    // Bounce 0..5 step 2; dir input held at 1 to show it is ignored
    add(2, 1, 0, 5, 2, 0, 0, 1, 0, 0, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 2, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 4, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 5, 1, 1);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 3, 0, 1);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 1, 0, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 1);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 2, 1, 1);
    // Prescale 2 with a 3-cycle pause
    add(0, 1, 0, 255, 1, 2, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 2, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 2, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 2, 1, 0);
    add(0, 1, 0, 255, 1, 2, 1, 0, 0, 3, 1, 0);
    // Load 200 clamped to 100 while a tick is due; divider restarts
    add(0, 1, 0, 100, 1, 1, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 100, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 100, 1, 1, 1, 1, 200, 100, 1, 0);
    add(0, 1, 0, 100, 1, 1, 1, 0, 0, 100, 1, 0);
    add(0, 1, 0, 100, 1, 1, 1, 0, 0, 0, 1, 1);
    // step 0 acts as 1
    add(0, 1, 0, 255, 0, 0, 0, 1, 5, 5, 1, 0);
    add(0, 1, 0, 255, 0, 0, 1, 0, 0, 6, 1, 0);
    // Count below new bounds, then down-wrap from min
    add(0, 1, 10, 20, 1, 0, 1, 0, 0, 10, 1, 0);
    add(0, 0, 10, 20, 1, 0, 1, 0, 0, 20, 0, 1);
    add(1, 0, 10, 20, 1, 0, 1, 0, 0, 19, 0, 0);
    // Overshoot beyond 8 bits clamps, no modular wrap
    add(0, 1, 0, 255, 10, 0, 0, 1, 248, 248, 1, 0);
    add(0, 1, 0, 255, 10, 0, 1, 0, 0, 255, 1, 1);
    add(0, 1, 0, 255, 10, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 255, 10, 0, 0, 1, 3, 3, 0, 0);
    add(1, 0, 0, 255, 10, 0, 1, 0, 0, 0, 0, 1);
    // min == max
    add(0, 1, 7, 7, 1, 0, 0, 1, 50, 7, 1, 0);
    add(0, 1, 7, 7, 1, 0, 1, 0, 0, 7, 1, 1);
    add(1, 1, 7, 7, 1, 0, 1, 0, 0, 7, 1, 0);
    add(2, 1, 7, 7, 1, 0, 1, 0, 0, 7, 0, 1);
    add(2, 1, 7, 7, 1, 0, 1, 0, 0, 7, 1, 1);
    // mode 11 behaves as wrap
    add(3, 1, 0, 3, 1, 0, 0, 1, 3, 3, 1, 0);
    add(3, 1, 0, 3, 1, 0, 1, 0, 0, 0, 1, 1);

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset count", int'(count), 0);
    check("reset cur_dir", int'(cur_dir), 1);
    check("reset tc", int'(tc), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset between edges right after a bounce reversal
    vecs.delete();
    add(2, 1, 0, 5, 2, 0, 0, 1, 0, 0, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 2, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 4, 1, 0);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 5, 1, 1);
    add(2, 1, 0, 5, 2, 0, 1, 0, 0, 3, 0, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check_vec($sformatf("rb%0d", i), vecs[i]);
    end
    #2 rst = 1'b1;
    #1;
    check("async rst count", int'(count), 0);
    check("async rst cur_dir", int'(cur_dir), 1);
    check("async rst tc", int'(tc), 0);
    @(posedge clk);
    #1;
    check("rst held count", int'(count), 0);

    // First tick comes prescale+1 enabled cycles after release
    h = '{en: 1'b1, dir: 1'b1, mode: 2'd0, mn: 8'd0, mx: 8'd255, st: 8'd1, pre: 16'd1,
          ld: 1'b0, lv: 8'd0, e_cnt: 8'd0, e_dir: 1'b1, e_tc: 1'b0};
    @(negedge clk);
    rst = 1'b0;
    drive(h);
    @(posedge clk);
    #1;
    check("post rst cycle1 count", int'(count), 0);
    @(posedge clk);
    #1;
    check("post rst cycle2 count", int'(count), 1);

    // Inverted bounds: flag set, load and ticks ignored
    h = '{en: 1'b0, dir: 1'b1, mode: 2'd0, mn: 8'd9, mx: 8'd4, st: 8'd1, pre: 16'd0,
          ld: 1'b0, lv: 8'd7, e_cnt: 8'd1, e_dir: 1'b1, e_tc: 1'b0};
    @(negedge clk);
    drive(h);
    #1;
    check("cfg_err flag", int'(cfg_err), 1);
    h.en = 1'b1;
    h.ld = 1'b1;
    apply(h);
    check("cfg_err load count", int'(count), 1);
    h.ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(h);
      check($sformatf("cfg_err tick%0d count", i), int'(count), 1);
      check($sformatf("cfg_err tick%0d tc", i), int'(tc), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_updown_counter.md
PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, count width; PRESCALE_W, default 16, prescaler width.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  run enable; 0 = pause.
- dir  in  1  direction; 1 = up, 0 = down.
- mode  in  2  end behaviour: 00 wrap, 01 saturate, 10 bounce; 11 is treated as wrap.
- min_val  in  WIDTH  lower bound.
- max_val  in  WIDTH  upper bound.
- step  in  WIDTH  increment per tick; 0 is treated as 1.
- prescale  in  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- cur_dir  out  1  effective direction, registered.
- tc  out  1  terminal-count pulse, registered.
- at_min, at_max  out  1 each  combinational; count==min_val and count==max_val respectively.
- cfg_err  out  1  combinational; min_val > max_val.

Function
REQ-003 Priority SHALL be rst > load > tick > hold.
REQ-004 Tick SHALL be generated when en=1 and the prescale divider equals prescale; the divider then returns to 0, otherwise it increments on each en=1 cycle.
REQ-005 en=0 SHALL freeze count, cur_dir and the divider; tc SHALL be 0.
REQ-006 Load SHALL act regardless of en:
- count <= load_val clamped to [min_val,max_val];
- divider <= 0;
- cur_dir <= dir.
REQ-007 In modes wrap and saturate, cur_dir SHALL take dir every cycle. In bounce mode, cur_dir SHALL change only on load or on reversal.
REQ-008 Arithmetic SHALL use WIDTH+1 bits; any overshoot beyond a bound clamps to that bound, with no modular wrap of the WIDTH-bit value.
REQ-009 Tick, count strictly inside the bounds: count moves by step toward cur_dir, clamped.
REQ-010 Tick, count at the terminal bound (max_val if up, min_val if down):
- wrap: count goes to the opposite bound;
- saturate: count holds;
- bounce: cur_dir inverts and count moves one step the other way, clamped.
REQ-011 Tick, count outside [min_val,max_val] (after reset or a bound change): count <= min_val if up, max_val if down; no tc.
REQ-012 tc SHALL be high exactly one cycle after a tick that wraps, reverses, or moves count onto its terminal bound from a different value. A saturate hold SHALL NOT pulse tc.
REQ-013 When min_val == max_val, every tick SHALL hold count; wrap and bounce modes pulse tc on each tick.
REQ-014 While cfg_err=1, ticks and loads SHALL leave count unchanged and the divider SHALL still run.
REQ-015 Latency SHALL be: count/cur_dir/tc update at the clock edge of the tick or load cycle; at_min/at_max follow count combinationally.

Reset
REQ-016 rst=1 SHALL immediately set count=0, cur_dir=1, tc=0, divider=0, independent of clk.
REQ-017 Release of rst SHALL be synchronised by the integrating level. The first tick SHALL occur prescale+1 enabled cycles after release.
REQ-018 Reset asserted mid-count or mid-load SHALL take precedence with no partial update.

Structure
REQ-019 Package ctr_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT, MODE_BOUNCE) and the default WIDTH/PRESCALE_W constants.
REQ-020 Sub-module ctr_prescaler SHALL implement the divider and tick (inputs en, clear, prescale; output tick). All bound/step logic SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios (WIDTH=8 unless stated):
- Wrap up, min=3, max=6, step=1, prescale=0 -> count 3,4,5,6,3; tc high in the cycle after reaching 6 and after the 6->3 wrap.
- Saturate down, step=4, load 10, min=0 -> count 6,2,0,0; one tc pulse only.
- Bounce, min=0, max=5, step=2, start at 0 up -> count 2,4,5,3,1,0,2; cur_dir toggles at 5 and at 0.
- prescale=2, en toggled 0 for 3 cycles mid-run -> ticks every 3 enabled cycles; count frozen while en=0.
- load_val=200 with max=100, concurrent with a tick -> count=100, no step applied, divider cleared.
- rst asserted asynchronously between edges mid-bounce -> count=0, cur_dir=1 immediately. min=9, max=4 -> cfg_err=1, count unchanged.
